// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: ISA word width
// and the loader FSM state encodings.
package imem_loader_pkg;

  localparam int INST_W_ISA = 19;

  localparam logic [2:0] ST_LEN_HI = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_B2     = 3'd2;
  localparam logic [2:0] ST_B1     = 3'd3;
  localparam logic [2:0] ST_B0     = 3'd4;
  localparam logic [2:0] ST_CSUM   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  // States in which the loader is still consuming frame bytes.
  function automatic logic is_load_state(input logic [2:0] s);
    return (s <= ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream into instruction words, writes
// them to instruction memory, and holds the CPU in reset until a good frame lands.
//
// Handshake: a byte is consumed on a rising edge where rx_valid && rx_ready;
// rx_valid without rx_ready leaves the byte with the source, and rx_ready never
// depends combinationally on rx_valid.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int INST_W = INST_W_ISA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [2:0]        fsm_state
);

  localparam int          CNT_W     = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic [15:0]       len;
  logic [CNT_W-1:0]  word_cnt;
  logic [7:0]        xor_acc;
  logic [INST_W-9:0] word_hi;
  logic              accept;
  logic [15:0]       len_rx;
  logic              len_bad;
  logic              last_word;
  logic              in_final;

  assign accept    = rx_valid && rx_ready;
  assign len_rx    = {len[15:8], rx_data};
  assign len_bad   = (len_rx == 16'd0) || ({1'b0, len_rx} > MAX_WORDS);
  assign last_word = (16'(word_cnt) + 16'd1) == len;
  assign in_final  = (state == ST_DONE) || (state == ST_ERR);
  assign fsm_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      ST_LEN_HI: if (accept) state_nx = ST_LEN_LO;
      ST_LEN_LO: if (accept) state_nx = len_bad ? ST_ERR : ST_B2;
      ST_B2:     if (accept) state_nx = ST_B1;
      ST_B1:     if (accept) state_nx = ST_B0;
      ST_B0:     if (accept) state_nx = last_word ? ST_CSUM : ST_B2;
      ST_CSUM:   if (accept) state_nx = ((xor_acc ^ rx_data) == 8'h00) ? ST_DONE : ST_ERR;
      ST_DONE,
      ST_ERR:    if (load_req) state_nx = ST_LEN_HI;
      default:   state_nx = ST_LEN_HI;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_LEN_HI;
      len        <= '0;
      word_cnt   <= '0;
      xor_acc    <= '0;
      word_hi    <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      rx_ready <= is_load_state(state_nx);
      imem_we  <= 1'b0;

      if (accept) begin
        xor_acc <= xor_acc ^ rx_data;
        case (state)
          ST_LEN_HI: len[15:8] <= rx_data;
          ST_LEN_LO: len[7:0]  <= rx_data;
          // Only the low bits of the first byte belong to the word.
          ST_B2:     word_hi[INST_W-9:8] <= rx_data[INST_W-17:0];
          ST_B1:     word_hi[7:0] <= rx_data;
          ST_B0: begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= {word_hi, rx_data};
            word_cnt   <= word_cnt + CNT_W'(1);
          end
          default: ;
        endcase
      end

      if (state_nx == ST_DONE && state != ST_DONE) begin
        cpu_hold  <= 1'b0;
        load_done <= 1'b1;
      end
      if (state_nx == ST_ERR && state != ST_ERR) begin
        load_err <= 1'b1;
      end

      // Restart keeps previously written words; only loader bookkeeping clears.
      if (in_final && load_req) begin
        load_done <= 1'b0;
        load_err  <= 1'b0;
        xor_acc   <= '0;
        word_cnt  <= '0;
        cpu_hold  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are driven byte-wise, expected
// memory writes are queued up front and checked by an independent monitor.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int INST_W = 19;
  localparam int EW     = ADDR_W + INST_W;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              load_req;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [2:0]        fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [23:0]   frame_words[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .load_req  (load_req),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset === 1'b1 && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("imem_write", 32'({imem_addr, imem_wdata}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int budget;
    g = 0;
    while (gaps && g < 3 && $urandom_range(0, 1) == 1) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    budget   = 0;
    while (rx_ready !== 1'b1 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 50) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout: got rx_ready=%0b expected 1", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Sends frame_words as a frame; checksum from the bench's own XOR unless fixed.
  task automatic send_frame(input bit gaps, input bit fixed_csum, input logic [7:0] csum_val,
                            input bit req_in_b2);
    logic [15:0] n;
    logic [7:0]  x;
    logic [23:0] w;
    n = 16'(frame_words.size());
    x = n[15:8] ^ n[7:0];
    send_byte(n[15:8], gaps);
    send_byte(n[7:0], gaps);
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      x = x ^ w[23:16] ^ w[15:8] ^ w[7:0];
      if (req_in_b2 && i == 0) load_req = 1'b1;
      send_byte(w[23:16], gaps);
      load_req = 1'b0;
      send_byte(w[15:8], gaps);
      send_byte(w[7:0], gaps);
    end
    send_byte(fixed_csum ? csum_val : x, gaps);
  endtask

  task automatic push_words();
    for (int i = 0; i < frame_words.size(); i++) begin
      exp_q.push_back({ADDR_W'(i), frame_words[i][18:0]});
    end
  endtask

  task automatic restart();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_load_done"}, 32'(load_done), 32'd1);
    check({tag, "_cpu_hold"},  32'(cpu_hold),  32'd0);
    check({tag, "_load_err"},  32'(load_err),  32'd0);
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    load_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready",  32'(rx_ready),   32'd0);
    check("rst_imem_we",   32'(imem_we),    32'd0);
    check("rst_imem_addr", 32'(imem_addr),  32'd0);
    check("rst_wdata",     32'(imem_wdata), 32'd0);
    check("rst_cpu_hold",  32'(cpu_hold),   32'd1);
    check("rst_load_done", 32'(load_done),  32'd0);
    check("rst_load_err",  32'(load_err),   32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rx_ready_after_rst", 32'(rx_ready), 32'd1);

    // Two words back-to-back; XOR of 00 02 01 23 45 07 FF FF is 0x62.
    frame_words = '{24'h012345, 24'h07FFFF};
    exp_q.push_back({8'h00, 19'h12345});
    exp_q.push_back({8'h01, 19'h7FFFF});
    send_frame(1'b0, 1'b1, 8'h62, 1'b0);
    check_done("good2");
    drain("good2_drain");
    restart();
    check("restart_rx_ready",  32'(rx_ready),  32'd1);
    check("restart_load_done", 32'(load_done), 32'd0);
    check("restart_cpu_hold",  32'(cpu_hold),  32'd1);

    // Same frame, bad checksum: words still written, then ERR.
    exp_q.push_back({8'h00, 19'h12345});
    exp_q.push_back({8'h01, 19'h7FFFF});
    send_frame(1'b0, 1'b1, 8'h00, 1'b0);
    check("badcs_load_err",  32'(load_err),  32'd1);
    check("badcs_cpu_hold",  32'(cpu_hold),  32'd1);
    check("badcs_rx_ready",  32'(rx_ready),  32'd0);
    check("badcs_load_done", 32'(load_done), 32'd0);
    drain("badcs_drain");
    restart();
    check("err_restart_load_err", 32'(load_err), 32'd0);
    check("err_restart_rx_ready", 32'(rx_ready), 32'd1);
    frame_words = '{24'hABCDEF, 24'h000001, 24'hF80000};
    exp_q.push_back({8'h00, 19'h3CDEF});
    exp_q.push_back({8'h01, 19'h00001});
    exp_q.push_back({8'h02, 19'h00000});
    send_frame(1'b0, 1'b0, 8'h00, 1'b0);
    check_done("reload");
    drain("reload_drain");
    restart();

    // Illegal lengths: zero and one past the memory depth.
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("len0_load_err", 32'(load_err), 32'd1);
    check("len0_rx_ready", 32'(rx_ready), 32'd0);
    check("len0_cpu_hold", 32'(cpu_hold), 32'd1);
    restart();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("len257_load_err", 32'(load_err), 32'd1);
    check("len257_rx_ready", 32'(rx_ready), 32'd0);
    drain("badlen_nowrite");
    restart();

    // Full-depth frame: 256 words, addresses 0..255 with no wrap.
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back({8'(i * 7), 8'(i), 8'(~i)});
    push_words();
    send_frame(1'b0, 1'b0, 8'h00, 1'b0);
    check_done("full");
    drain("full_drain");
    restart();

    // Four words, back-to-back then with random rx_valid gaps; same writes expected.
    frame_words = '{24'h123456, 24'h00BEEF, 24'hFFFFFF, 24'h040201};
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back({8'h00, 19'h23456});
      exp_q.push_back({8'h01, 19'h0BEEF});
      exp_q.push_back({8'h02, 19'h7FFFF});
      exp_q.push_back({8'h03, 19'h40201});
      send_frame(pass == 1, 1'b0, 8'h00, 1'b0);
      check_done(pass == 1 ? "gaps4" : "b2b4");
      drain(pass == 1 ? "gaps4_drain" : "b2b4_drain");
      restart();
    end

    // load_req during B2 of word 0 is ignored.
    frame_words = '{24'h0A0B0C, 24'h111111};
    exp_q.push_back({8'h00, 19'h20B0C});
    exp_q.push_back({8'h01, 19'h11111});
    send_frame(1'b0, 1'b0, 8'h00, 1'b1);
    check_done("req_ignored");
    drain("req_ignored_drain");
    restart();

    // Asynchronous reset while B1 of word 1 is on the bus.
    exp_q.push_back({8'h00, 19'h55555});
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h01, 1'b0);
    rx_data  = 8'h22;
    rx_valid = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    check("midrst_rx_ready",  32'(rx_ready),   32'd0);
    check("midrst_imem_we",   32'(imem_we),    32'd0);
    check("midrst_addr",      32'(imem_addr),  32'd0);
    check("midrst_wdata",     32'(imem_wdata), 32'd0);
    check("midrst_cpu_hold",  32'(cpu_hold),   32'd1);
    check("midrst_load_done", 32'(load_done),  32'd0);
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_rx_ready_after", 32'(rx_ready), 32'd1);
    frame_words = '{24'h076543};
    exp_q.push_back({8'h00, 19'h76543});
    send_frame(1'b0, 1'b0, 8'h00, 1'b0);
    check_done("after_rst");
    drain("after_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
